p_issue_fifo: RTL and testbench
===============================

Name: p_issue_fifo

Overview:
- Upstream feeder for the piston decode controller.
- Buffers control words from the piston sequencer in a DEPTH-entry FIFO and presents the head entry as a req/ack transaction (o_kp_req, o_k_ctrl) to the decode controller.
- Also provides occupancy, per-class issue counters (short path k_ctrl<8, long path k_ctrl>=8) and a stall watchdog.

Parameters:
- SELOU, 4, width of k_ctrl control word.
- DEPTH, 8, FIFO entries; power of two, >=2.
- CNTW, 16, width of per-class issue counters.
- TIMEOUT, 1024, cycles o_kp_req may stay high without ack before the stall flag sets.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- i_wr_valid  in  1  sequencer presents a control word.
- o_wr_ready  out  1  FIFO can accept a word this cycle.
- i_wr_ctrl  in  SELOU  control word to enqueue.
- i_flush  in  1  discard queued, not-yet-issued entries.
- o_kp_req  out  1  request to decode controller.
- i_kp_ack  in  1  decode controller completion; may be combinational from o_kp_req.
- o_k_ctrl  out  SELOU  head control word, valid while o_kp_req=1.
- o_count  out  log2(DEPTH)+1  current occupancy.
- o_sk_issued  out  CNTW  completed short-path transactions.
- o_lk_issued  out  CNTW  completed long-path transactions.
- o_stall  out  1  sticky watchdog flag.

Behaviour:
- Reset (synchronous, active-high; reset wins over all other inputs):
  - count=0, pointers=0, o_kp_req=0, counters=0, o_stall=0, watchdog=0.
  - o_k_ctrl is don't-care while o_kp_req=0.
- Write side:
  - o_wr_ready = (count < DEPTH), from registered count only.
  - A word is accepted when i_wr_valid & o_wr_ready.
  - No write pass-through when full: a pop in the same cycle does not make a full FIFO accept.
- Read side:
  - o_kp_req = (count != 0), from registers only.
  - o_kp_req must not depend combinationally on i_kp_ack; the decode controller's ack is combinational from req, so such a path is a loop.
  - o_k_ctrl = mem[rd_ptr].
  - A transaction completes on any cycle with o_kp_req & i_kp_ack. On completion: pop, rd_ptr++.
  - o_kp_req and o_k_ctrl stay stable from assertion until completion.
  - i_kp_ack while o_kp_req=0 is ignored.
- Throughput and latency:
  - One transaction per cycle when acks are immediate.
  - Next entry is presented the cycle after a pop if count after the pop is nonzero.
  - Write to an empty FIFO: o_kp_req rises the next cycle (1-cycle latency).
- Occupancy:
  - Write and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Class counters:
  - On completion, o_sk_issued increments if head k_ctrl<8, else o_lk_issued.
  - Both saturate at all-ones and do not wrap.
- Flush:
  - If o_kp_req=0: FIFO empties next cycle.
  - If o_kp_req=1 and no ack this cycle: the head entry is retained and its request stays up until acked; all other entries are dropped. Aborting would leave the decode controller's partial sub-ack state stale. Next count=1.
  - If o_kp_req=1 with ack in the same cycle: the completion counts, and the FIFO is empty next cycle.
  - A write in a flush cycle is discarded; o_wr_ready is still reported normally.
- Watchdog:
  - Counter clears on completion or when o_kp_req=0, and increments while o_kp_req & ~i_kp_ack.
  - When the counter reaches TIMEOUT, o_stall sets and remains set until reset.
  - The watchdog never blocks traffic.

Test Plan:
- Write 3 words (2, 9, 5) into an empty FIFO; ack tied high → o_kp_req rises 1 cycle after the first write; k_ctrl sequence 2, 9, 5 on consecutive cycles; o_sk_issued=2, o_lk_issued=1.
- DEPTH=8: fill with 8 words while ack=0 → o_wr_ready=0 and count=8. Then ack for 1 cycle with i_wr_valid high → count=7; the write is not accepted that cycle and is accepted the next.
- Head k_ctrl=12, ack withheld for 5 cycles → o_kp_req and o_k_ctrl=12 stable for all 5 cycles; then ack → pop, o_lk_issued=1.
- Count=4, req pending, no ack, assert i_flush → next cycle count=1 with the same head; ack → count=0, o_kp_req=0.
- TIMEOUT=16, one entry, ack held low → o_stall=1 after 16 req cycles; stays 1 after a later ack; cleared only by reset.
- Assert reset mid-stream with count=5 → next cycle o_kp_req=0, count=0, counters=0; a write in the cycle after reset deasserts produces o_kp_req one cycle later.

Source files
------------

// File: rtl/p_issue_fifo.sv
// p_issue_fifo: control-word FIFO feeding the decode controller via req/ack, with occupancy, class issue counters and a stall watchdog. Ports: clk, reset (sync, active-high); write side i_wr_valid/o_wr_ready/i_wr_ctrl; i_flush; read side o_kp_req/i_kp_ack/o_k_ctrl; status o_count, o_sk_issued, o_lk_issued, o_stall.
module p_issue_fifo #(
  parameter int SELOU   = 4,
  parameter int DEPTH   = 8,
  parameter int CNTW    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [SELOU-1:0]         i_wr_ctrl,
  input  logic                     i_flush,
  output logic                     o_kp_req,
  input  logic                     i_kp_ack,
  output logic [SELOU-1:0]         o_k_ctrl,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [CNTW-1:0]          o_sk_issued,
  output logic [CNTW-1:0]          o_lk_issued,
  output logic                     o_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
  logic [SELOU-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [WW-1:0] wd, wd_next;
  logic push, done, short_k;
  assign o_wr_ready = o_count != FULL;
  assign o_kp_req   = o_count != '0;
  assign o_k_ctrl   = mem[rd_ptr];
  assign done       = o_kp_req & i_kp_ack;
  assign push       = i_wr_valid & o_wr_ready & ~i_flush;
  assign short_k    = {{(32 - SELOU){1'b0}}, o_k_ctrl} < 32'd8;
  assign wd_next    = (~o_kp_req | done) ? '0 : (wd == TMO ? wd : wd + 1'b1);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= i_wr_ctrl;
  always_ff @(posedge clk) begin
    if (reset) begin
      o_count     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      o_sk_issued <= '0;
      o_lk_issued <= '0;
      wd          <= '0;
      o_stall     <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + AW'(done);
      // a pending unacked head survives a flush so the consumer never sees an aborted request
      if (i_flush) begin
        o_count <= (AW + 1)'(o_kp_req & ~i_kp_ack);
        wr_ptr  <= rd_ptr + AW'(o_kp_req);
      end else begin
        o_count <= o_count + (AW + 1)'(push) - (AW + 1)'(done);
        wr_ptr  <= wr_ptr + AW'(push);
      end
      if (done & short_k & ~&o_sk_issued) o_sk_issued <= o_sk_issued + 1'b1;
      if (done & ~short_k & ~&o_lk_issued) o_lk_issued <= o_lk_issued + 1'b1;
      wd <= wd_next;
      if (wd_next == TMO) o_stall <= 1'b1;
    end
  end
endmodule

// File: tb/tb_p_issue_fifo.sv
// tb_p_issue_fifo: randomized and directed check of p_issue_fifo against a queue-based reference model.
module tb_p_issue_fifo;
  localparam int SELOU = 4, DEPTH = 8, CNTW = 4, TIMEOUT = 16;
  localparam int MAXC = (1 << CNTW) - 1;
  logic clk = 0, reset, i_wr_valid, i_flush, i_kp_ack;
  logic [SELOU-1:0] i_wr_ctrl, o_k_ctrl;
  logic o_wr_ready, o_kp_req, o_stall;
  logic [$clog2(DEPTH):0] o_count;
  logic [CNTW-1:0] o_sk_issued, o_lk_issued;
  int n_tests = 0, n_fail = 0;
  logic [SELOU-1:0] q[$];
  int sk = 0, lk = 0, waitc = 0;
  bit stl = 0;
  always #5 clk = ~clk;
  p_issue_fifo #(.SELOU(SELOU), .DEPTH(DEPTH), .CNTW(CNTW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_ctrl(i_wr_ctrl), .i_flush(i_flush), .o_kp_req(o_kp_req), .i_kp_ack(i_kp_ack),
    .o_k_ctrl(o_k_ctrl), .o_count(o_count), .o_sk_issued(o_sk_issued),
    .o_lk_issued(o_lk_issued), .o_stall(o_stall)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [SELOU-1:0] c, input logic f, input logic a, input logic r);
    bit req, acc;
    logic [SELOU-1:0] h;
    i_wr_valid = v; i_wr_ctrl = c; i_flush = f; i_kp_ack = a; reset = r;
    chk("req", 32'(o_kp_req), 32'(q.size() != 0));
    chk("ready", 32'(o_wr_ready), 32'(q.size() < DEPTH));
    chk("count", 32'(o_count), 32'(q.size()));
    if (q.size() != 0) chk("k_ctrl", 32'(o_k_ctrl), 32'(q[0]));
    chk("sk", 32'(o_sk_issued), 32'(sk));
    chk("lk", 32'(o_lk_issued), 32'(lk));
    chk("stall", 32'(o_stall), 32'(stl));
    @(posedge clk);
    if (r) begin
      q.delete(); sk = 0; lk = 0; waitc = 0; stl = 0;
    end else begin
      req = q.size() != 0;
      acc = v && q.size() < DEPTH;
      if (req && a) begin
        if (q[0] < 8) sk = (sk == MAXC) ? sk : sk + 1;
        else lk = (lk == MAXC) ? lk : lk + 1;
      end
      if (req && !a) begin
        waitc++;
        if (waitc >= TIMEOUT) stl = 1;
      end else waitc = 0;
      if (f) begin
        if (req && !a) begin
          h = q[0];
          q.delete();
          q.push_back(h);
        end else q.delete();
      end else begin
        if (req && a) void'(q.pop_front());
        if (acc) q.push_back(c);
      end
    end
    #1;
  endtask
  initial begin
    reset = 1; i_wr_valid = 0; i_wr_ctrl = 0; i_flush = 0; i_kp_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 4'd3, 1, 1, 1);
    step(1, 4'd2, 0, 1, 0);
    step(1, 4'd9, 0, 1, 0);
    step(1, 4'd5, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    chk("tp1_sk", 32'(o_sk_issued), 32'd2);
    chk("tp1_lk", 32'(o_lk_issued), 32'd1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, SELOU'(i), 0, 0, 0);
    step(1, 4'd3, 0, 0, 0);
    step(1, 4'd7, 0, 1, 0);
    step(1, 4'd7, 0, 0, 0);
    chk("tp2_count", 32'(o_count), 32'd8);
    step(0, 0, 0, 0, 1);
    step(1, 4'd12, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("tp3_lk", 32'(o_lk_issued), 32'd1);
    for (int i = 0; i < 4; i++) step(1, SELOU'(i + 10), 0, 0, 0);
    step(1, 4'd1, 1, 0, 0);
    chk("tp4_count", 32'(o_count), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("tp4_req", 32'(o_kp_req), 32'd0);
    step(1, 4'd6, 0, 0, 0);
    repeat (TIMEOUT + 3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    chk("tp5_stall", 32'(o_stall), 32'd1);
    for (int i = 0; i < 5; i++) step(1, SELOU'(i), 0, 0, 0);
    step(1, 4'd9, 1, 1, 1);
    step(1, 4'd8, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int p = 0; p < 30; p++) begin
      int ap, vp;
      ap = (p % 5 == 0) ? 0 : int'($urandom_range(10, 100));
      vp = int'($urandom_range(20, 95));
      for (int k = 0; k < 80; k++)
        step($urandom_range(0, 99) < vp, SELOU'($urandom), $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < ap, $urandom_range(0, 999) < 4);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
